// File: rtl/apb4_cpuif_pkg.sv
// apb4_cpuif_pkg -- shared types and helpers for the APB4 to CPU-interface bridge.
//   state_e  : bridge FSM states
//   addr_lsb : number of low address bits dropped to word-align for a bus width
package apb4_cpuif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic int unsigned addr_lsb(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb4_cpuif_bridge_if.sv
// apb4_cpuif_bridge_if -- APB4 completer bus plus the internal CPU-interface request/ack bus.
//   slave  : bridge side (takes APB, drives cpuif_req*, takes cpuif acks)
//   master : environment side (APB requester and cpuif target)
interface apb4_cpuif_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  // APB4
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [2:0]              PPROT;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;
  // CPU interface
  logic                    cpuif_req;
  logic                    cpuif_req_is_wr;
  logic [ADDR_WIDTH-1:0]   cpuif_addr;
  logic [DATA_WIDTH-1:0]   cpuif_wr_data;
  logic [DATA_WIDTH-1:0]   cpuif_wr_biten;
  logic                    cpuif_req_stall;
  logic                    cpuif_rd_ack;
  logic                    cpuif_rd_err;
  logic [DATA_WIDTH-1:0]   cpuif_rd_data;
  logic                    cpuif_wr_ack;
  logic                    cpuif_wr_err;

  modport slave (
    input  PSEL, PENABLE, PWRITE, PPROT, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR,
    output cpuif_req, cpuif_req_is_wr, cpuif_addr, cpuif_wr_data, cpuif_wr_biten,
    input  cpuif_req_stall, cpuif_rd_ack, cpuif_rd_err, cpuif_rd_data, cpuif_wr_ack, cpuif_wr_err
  );

  modport master (
    output PSEL, PENABLE, PWRITE, PPROT, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR,
    input  cpuif_req, cpuif_req_is_wr, cpuif_addr, cpuif_wr_data, cpuif_wr_biten,
    output cpuif_req_stall, cpuif_rd_ack, cpuif_rd_err, cpuif_rd_data, cpuif_wr_ack, cpuif_wr_err
  );

endinterface

// File: rtl/apb4_cpuif_bridge.sv
// apb4_cpuif_bridge -- APB4 completer that turns each APB transfer into one
// request on a simple CPU interface and returns the ack/err/data as the APB response.
//   clk    : single clock, rising edge
//   arst_n : asynchronous active-low reset
//   bus    : apb4_cpuif_bridge_if.slave (APB4 + cpuif signals)
// All outputs are registered. DATA_WIDTH must be 8, 16, 32 or 64.
// TIMEOUT_CYCLES bounds the WAIT state; 0 means wait forever.
module apb4_cpuif_bridge
  import apb4_cpuif_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                clk,
  input logic                arst_n,
  apb4_cpuif_bridge_if.slave bus
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ISSUE = ST_ISSUE;
  localparam logic [1:0] S_WAIT  = ST_WAIT;
  localparam logic [1:0] S_RESP  = ST_RESP;

  localparam int                    LSB        = addr_lsb(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~((ADDR_WIDTH'(1) << LSB) - ADDR_WIDTH'(1));
  localparam int                    CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic                  req;
  logic                  req_is_wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] wr_biten;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;
  logic                  slverr;

  logic [DATA_WIDTH-1:0] biten_nxt;
  logic                  ack;
  logic                  err;
  logic                  tmo;

  // Byte strobes to bit enables.
  always_comb begin
    biten_nxt = '0;
    for (int i = 0; i < DATA_WIDTH/8; i++) biten_nxt[i*8 +: 8] = {8{bus.PSTRB[i]}};
  end

  // Only the ack/err matching the captured direction counts.
  assign ack = req_is_wr ? bus.cpuif_wr_ack : bus.cpuif_rd_ack;
  assign err = req_is_wr ? bus.cpuif_wr_err : bus.cpuif_rd_err;
  // This WAIT cycle is the TIMEOUT_CYCLES-th one.
  assign tmo = (TIMEOUT_CYCLES != 0) && (int'(cnt) == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req       <= 1'b0;
      req_is_wr <= 1'b0;
      addr      <= '0;
      wr_data   <= '0;
      wr_biten  <= '0;
      rdata     <= '0;
      ready     <= 1'b0;
      slverr    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Accept only the setup phase; PSEL drop later does not cancel.
          if (bus.PSEL && !bus.PENABLE) begin
            state     <= S_ISSUE;
            req       <= 1'b1;
            req_is_wr <= bus.PWRITE;
            addr      <= bus.PADDR & ALIGN_MASK;
            wr_data   <= bus.PWDATA;
            wr_biten  <= biten_nxt;
            cnt       <= '0;
          end
        end
        S_ISSUE: begin
          // While stalled the request (and any ack) is held off.
          if (!bus.cpuif_req_stall) begin
            req <= 1'b0;
            if (ack) begin
              state  <= S_RESP;
              ready  <= 1'b1;
              rdata  <= req_is_wr ? '0 : bus.cpuif_rd_data;
              slverr <= err;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Ack has priority over timeout in the same cycle.
          if (ack) begin
            state  <= S_RESP;
            ready  <= 1'b1;
            rdata  <= req_is_wr ? '0 : bus.cpuif_rd_data;
            slverr <= err;
          end else if (tmo) begin
            state  <= S_RESP;
            ready  <= 1'b1;
            rdata  <= '0;
            slverr <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state  <= S_IDLE;
          ready  <= 1'b0;
          rdata  <= '0;
          slverr <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpuif_req       = req;
  assign bus.cpuif_req_is_wr = req_is_wr;
  assign bus.cpuif_addr      = addr;
  assign bus.cpuif_wr_data   = wr_data;
  assign bus.cpuif_wr_biten  = wr_biten;
  assign bus.PRDATA          = rdata;
  assign bus.PREADY          = ready;
  assign bus.PSLVERR         = slverr;

endmodule

// File: tb/tb_apb4_cpuif_bridge.sv
// tb_apb4_cpuif_bridge -- directed and randomized transfers checked against a
// transfer-level timing/response model.
module tb_apb4_cpuif_bridge;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int TMO = 16;

  logic clk;
  logic arst_n;
  int   n_chk;
  int   n_err;

  apb4_cpuif_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  apb4_cpuif_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.PSEL            = 1'b0;
    bus.PENABLE         = 1'b0;
    bus.cpuif_req_stall = 1'b0;
    bus.cpuif_rd_ack    = 1'b0;
    bus.cpuif_wr_ack    = 1'b0;
    bus.cpuif_rd_err    = 1'b0;
    bus.cpuif_wr_err    = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".req"},    bus.cpuif_req, 0);
    chk({tag, ".is_wr"},  bus.cpuif_req_is_wr, 0);
    chk({tag, ".addr"},   bus.cpuif_addr, 0);
    chk({tag, ".wdata"},  bus.cpuif_wr_data, 0);
    chk({tag, ".biten"},  bus.cpuif_wr_biten, 0);
    chk({tag, ".prdata"}, bus.PRDATA, 0);
    chk({tag, ".pready"}, bus.PREADY, 0);
    chk({tag, ".slverr"}, bus.PSLVERR, 0);
  endtask

  // One APB transfer, called at a negedge with the bridge idle.
  // n_stall: ISSUE cycles with stall; d: 0 = ack in accepting ISSUE cycle,
  // k>0 = ack in k-th WAIT cycle (k > TMO never acks in time).
  // stray: random non-matching acks; late: matching ack after completion.
  task automatic run_xfer(input string tag, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] strb,
                          input int n_stall, input int d, input bit err,
                          input logic [31:0] rd, input bit drop, input bit stray,
                          input bit late);
    int          w, resp_e, j;
    bit          hit, exp_err;
    logic [31:0] exp_rd, exp_addr, exp_biten;
    w         = (d == 0) ? 0 : ((d < TMO) ? d : TMO);
    resp_e    = 2 + n_stall + w;
    exp_err   = (d <= TMO) ? err : 1'b1;
    exp_rd    = (!wr && d <= TMO) ? rd : 32'h0;
    exp_addr  = a & 32'hFFFF_FFFC;
    for (int i = 0; i < 4; i++) exp_biten[i*8 +: 8] = {8{strb[i]}};

    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = a;
    bus.PWDATA  = wd;
    bus.PSTRB   = strb;
    bus.PPROT   = 3'($urandom);
    bus.cpuif_req_stall = 1'b0;
    bus.cpuif_rd_ack    = 1'b0;
    bus.cpuif_wr_ack    = 1'b0;

    for (int e = 1; e <= resp_e; e++) begin
      @(negedge clk);
      chk({tag, ".req"},    bus.cpuif_req, (e <= n_stall + 1));
      chk({tag, ".pready"}, bus.PREADY, (e == resp_e));
      if (e <= n_stall + 1) begin
        chk({tag, ".is_wr"}, bus.cpuif_req_is_wr, wr);
        chk({tag, ".addr"},  bus.cpuif_addr, exp_addr);
        if (wr) begin
          chk({tag, ".wdata"}, bus.cpuif_wr_data, wd);
          chk({tag, ".biten"}, bus.cpuif_wr_biten, exp_biten);
        end
      end
      if (e == resp_e) begin
        chk({tag, ".prdata"}, bus.PRDATA, exp_rd);
        chk({tag, ".slverr"}, bus.PSLVERR, exp_err);
      end else begin
        chk({tag, ".prdata0"}, bus.PRDATA, 0);
        chk({tag, ".slverr0"}, bus.PSLVERR, 0);
      end
      // inputs for the cycle after edge e
      bus.PSEL    = (e != resp_e) && !drop;
      bus.PENABLE = (e != resp_e) && !drop;
      j   = e - (n_stall + 1);
      hit = (e < resp_e) && (j == d);
      bus.cpuif_req_stall = (e <= n_stall) ? 1'b1 : ((j >= 1) ? 1'($urandom) : 1'b0);
      if (wr) begin
        bus.cpuif_wr_ack  = hit;
        bus.cpuif_wr_err  = hit ? err : 1'($urandom);
        bus.cpuif_rd_ack  = stray ? 1'($urandom) : 1'b0;
        bus.cpuif_rd_err  = 1'($urandom);
        bus.cpuif_rd_data = $urandom;
      end else begin
        bus.cpuif_rd_ack  = hit;
        bus.cpuif_rd_err  = hit ? err : 1'($urandom);
        bus.cpuif_rd_data = hit ? rd : $urandom;
        bus.cpuif_wr_ack  = stray ? 1'($urandom) : 1'b0;
        bus.cpuif_wr_err  = 1'($urandom);
      end
    end

    @(negedge clk);
    chk({tag, ".post.pready"}, bus.PREADY, 0);
    chk({tag, ".post.req"},    bus.cpuif_req, 0);
    chk({tag, ".post.prdata"}, bus.PRDATA, 0);
    chk({tag, ".post.slverr"}, bus.PSLVERR, 0);
    drive_idle();
    if (late) begin
      if (wr) begin bus.cpuif_wr_ack = 1'b1; bus.cpuif_wr_err = 1'b1; end
      else    begin bus.cpuif_rd_ack = 1'b1; bus.cpuif_rd_err = 1'b1; end
      bus.cpuif_rd_data = $urandom;
    end
    @(negedge clk);
    chk({tag, ".late.req"},    bus.cpuif_req, 0);
    chk({tag, ".late.pready"}, bus.PREADY, 0);
    chk({tag, ".late.slverr"}, bus.PSLVERR, 0);
    drive_idle();
  endtask

  initial begin
    int r, dd;
    n_chk  = 0;
    n_err  = 0;
    arst_n = 1'b0;
    drive_idle();
    bus.PWRITE        = 1'b0;
    bus.PPROT         = 3'h0;
    bus.PADDR         = '0;
    bus.PWDATA        = '0;
    bus.PSTRB         = '0;
    bus.cpuif_rd_data = '0;
    #2 chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);

    run_xfer("wr_fast",  1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 32'h0, 0, 0, 0);
    run_xfer("rd_wait3", 0, 32'h13, 32'h0, 4'h0, 0, 4, 0, 32'h12345678, 0, 0, 0);
    run_xfer("wr_stall", 1, 32'h20, 32'hA5A5_5A5A, 4'h5, 4, 1, 0, 32'h0, 0, 0, 0);
    run_xfer("rd_tmo",   0, 32'h30, 32'h0, 4'h0, 0, 1000, 0, 32'hCAFE_F00D, 0, 0, 1);
    run_xfer("rd_err",   0, 32'h40, 32'h0, 4'h0, 0, 2, 1, 32'h0BAD_0BAD, 0, 1, 0);
    run_xfer("wr_strb0", 1, 32'h50, 32'h1111_2222, 4'h0, 1, 0, 0, 32'h0, 0, 0, 0);
    run_xfer("rd_edge",  0, 32'h64, 32'h0, 4'h0, 0, TMO, 0, 32'h7777_8888, 0, 0, 0);
    run_xfer("rd_drop",  0, 32'h68, 32'h0, 4'h0, 1, 3, 0, 32'h0102_0304, 1, 0, 0);

    // Reset while in WAIT: abandon the transfer, then resume normally.
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 32'h7C; bus.PWDATA = 32'hFFFF_0000; bus.PSTRB = 4'hC;
    @(negedge clk);
    bus.PENABLE = 1'b1;
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b0;
    #1 chk_all_zero("rst_wait");
    @(negedge clk);
    drive_idle();
    arst_n = 1'b1;
    @(negedge clk);
    chk("rst_wait.idle.req", bus.cpuif_req, 0);
    run_xfer("post_rst", 1, 32'h84, 32'h1357_9BDF, 4'h3, 0, 1, 0, 32'h0, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       dd = $urandom_range(0, 5);
      else if (r == 7) dd = TMO;
      else if (r == 8) dd = TMO + 1;
      else             dd = 1000;
      run_xfer("rand", 1'($urandom), $urandom, $urandom, 4'($urandom),
               $urandom_range(0, 3), dd, 1'($urandom), $urandom,
               ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/apb4_cpuif_bridge.md
APB4_CPUIF_BRIDGE -- requirements
Module: apb4_cpuif_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bus data width in bits; only 8, 16, 32 or 64 are legal.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, bus address width in bits.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum number of WAIT cycles before an error completion; 0 disables the timeout.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port arst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port PSEL, input, 1, APB select.
REQ-007 SHALL have port PENABLE, input, 1, APB access phase.
REQ-008 SHALL have port PWRITE, input, 1, 1 = write.
REQ-009 SHALL have port PPROT, input, 3, protection bits, ignored.
REQ-010 SHALL have port PADDR, input, ADDR_WIDTH, byte address.
REQ-011 SHALL have port PWDATA, input, DATA_WIDTH, write data.
REQ-012 SHALL have port PSTRB, input, DATA_WIDTH/8, byte strobes; ignored on reads.
REQ-013 SHALL have port PRDATA, output, DATA_WIDTH, read data.
REQ-014 SHALL have port PREADY, output, 1, transfer complete.
REQ-015 SHALL have port PSLVERR, output, 1, transfer error.
REQ-016 SHALL have port cpuif_req, output, 1, internal request strobe.
REQ-017 SHALL have port cpuif_req_is_wr, output, 1, request is a write.
REQ-018 SHALL have port cpuif_addr, output, ADDR_WIDTH, word-aligned address: PADDR with the low log2(DATA_WIDTH/8) bits forced to 0.
REQ-019 SHALL have port cpuif_wr_data, output, DATA_WIDTH, write data.
REQ-020 SHALL have port cpuif_wr_biten, output, DATA_WIDTH, bit enables, each PSTRB bit replicated 8 times.
REQ-021 SHALL have port cpuif_req_stall, input, 1, target cannot accept the request this cycle.
REQ-022 SHALL have port cpuif_rd_ack, input, 1, read done.
REQ-023 SHALL have port cpuif_rd_err, input, 1, read error, qualified by cpuif_rd_ack.
REQ-024 SHALL have port cpuif_rd_data, input, DATA_WIDTH, read data, qualified by cpuif_rd_ack.
REQ-025 SHALL have port cpuif_wr_ack, input, 1, write done.
REQ-026 SHALL have port cpuif_wr_err, input, 1, write error, qualified by cpuif_wr_ack.

Function
REQ-027 SHALL implement an FSM with states IDLE, ISSUE, WAIT and RESP, and all outputs SHALL be registered.
REQ-028 IDLE: on a clock edge that samples PSEL=1 and PENABLE=0, the block SHALL capture address, direction, data and biten, clear the timeout counter, and move to ISSUE; any other input pattern SHALL leave it in IDLE.
REQ-029 ISSUE: cpuif_req SHALL be 1; if cpuif_req_stall=1 the block SHALL stay in ISSUE with the request held stable; otherwise it SHALL go to WAIT, or directly to RESP if the matching ack (rd_ack for reads, wr_ack for writes) is already 1 in that cycle.
REQ-030 cpuif_req SHALL be 0 in every state except ISSUE.
REQ-031 WAIT: on the matching ack the block SHALL capture PRDATA (reads only) and PSLVERR from the matching err input, then go to RESP.
REQ-032 WAIT timeout: the counter SHALL increment each WAIT cycle; when it reaches TIMEOUT_CYCLES without an ack (TIMEOUT_CYCLES > 0), the block SHALL go to RESP with PSLVERR=1 and PRDATA=0.
REQ-033 If an ack and the timeout occur in the same cycle, the ack SHALL win.
REQ-034 RESP: PREADY SHALL be 1 for exactly one cycle, after which the block SHALL return to IDLE.
REQ-035 PRDATA and PSLVERR SHALL be 0 in every state except RESP.
REQ-036 Any ack arriving outside ISSUE or WAIT (including a late ack after a timeout) SHALL be ignored, as SHALL a non-matching ack.
REQ-037 If PSEL drops before RESP, the transfer SHALL still complete internally; the RESP cycle still occurs and the response is discarded.
REQ-038 A write with PSTRB=0 SHALL still issue a request, with cpuif_wr_biten=0.
REQ-039 Minimum latency, from the setup-sampling edge to PREADY high, SHALL be 2 edges (no stall, same-cycle ack).

Reset
REQ-040 On arst_n=0 the block SHALL asynchronously enter IDLE with every output and the counter at 0; an in-flight transfer SHALL be abandoned with no response, and operation SHALL resume on the first edge after arst_n rises.

Structure
REQ-041 Package apb4_cpuif_pkg SHALL hold the state enum and a function computing the address-alignment bit count from DATA_WIDTH.
REQ-042 The design SHALL have no sub-modules; the counter and strobe expansion are inline.

Verification
REQ-043 The bench SHALL cover: write 0x10 = 0xDEADBEEF, strobe 0xF, same-cycle wr_ack -> cpuif_wr_biten=0xFFFFFFFF, PREADY 2 edges after setup, PSLVERR=0.
REQ-044 The bench SHALL cover: read 0x13, rd_ack after 3 WAIT cycles with rd_data 0x12345678 -> cpuif_addr=0x10, PRDATA=0x12345678, PREADY high for 1 cycle.
REQ-045 The bench SHALL cover: write with PSTRB=0x5 and stall held 4 cycles -> cpuif_req high and stable for 5 cycles, cpuif_wr_biten=0x00FF00FF.
REQ-046 The bench SHALL cover: read with no ack, TIMEOUT_CYCLES=16 -> PSLVERR=1 and PRDATA=0 after 16 WAIT cycles; a rd_ack 2 cycles later -> no effect.
REQ-047 The bench SHALL cover: read with rd_err=1 on ack -> PSLVERR=1; a wr_ack pulse during that read -> ignored.
REQ-048 The bench SHALL cover: arst_n asserted in WAIT -> all outputs 0 immediately, and the next transfer completes normally.
